// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-port i2c_control access arbiter:
// FSM state encoding, the latched request bundle and parameter defaults.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } arb_state_e;

    localparam int REQ_W = 66;

    // Field order matches the REQ_W bundle: {rd, addr_mode, addr, wrdata, dev_id, dly}.
    typedef struct packed {
        logic        rd;
        logic        addr_mode;
        logic [15:0] addr;
        logic [7:0]  wrdata;
        logic [7:0]  dev_id;
        logic [31:0] dly;
    } req_t;

    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd2000000;
    localparam logic [7:0]  GAP_CYC_DEF     = 8'd100;

endpackage

// File: rtl/i2c_arb_pick.sv
// Two-way request picker: fixed priority (port 0) or round-robin, where the
// priority pointer moves to the other port only when a grant is taken.
module i2c_arb_pick #(
    parameter int ARB_MODE = 0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       gnt_o
);

    logic prio_q, prio_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_o = 1'b0;
        case (req_i)
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = (ARB_MODE == 1) ? prio_q : 1'b0;
            default: gnt_o = 1'b0;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (take_i && (req_i != 2'b00)) begin
            prio_d = ~gnt_o;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/i2c_access_arbiter.sv
// Shares one i2c_control master between the init sequencer (port 0) and the
// runtime tuning path (port 1), with NACK retry, retry gap and timeout abort.
module i2c_access_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          ARB_MODE    = 0,
    parameter int          MAX_RETRY   = 3,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [7:0]  GAP_CYC     = GAP_CYC_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,

    input  logic        m0_req,
    input  logic        m0_rd,
    input  logic [15:0] m0_addr,
    input  logic        m0_addr_mode,
    input  logic [7:0]  m0_wrdata,
    input  logic [7:0]  m0_dev_id,
    input  logic [31:0] m0_dly,
    output logic        m0_done,
    output logic        m0_err,
    output logic [7:0]  m0_rddata,

    input  logic        m1_req,
    input  logic        m1_rd,
    input  logic [15:0] m1_addr,
    input  logic        m1_addr_mode,
    input  logic [7:0]  m1_wrdata,
    input  logic [7:0]  m1_dev_id,
    input  logic [31:0] m1_dly,
    output logic        m1_done,
    output logic        m1_err,
    output logic [7:0]  m1_rddata,

    output logic        i2c_wrreg_req,
    output logic        i2c_rdreg_req,
    output logic [15:0] i2c_addr,
    output logic        i2c_addr_mode,
    output logic [7:0]  i2c_wrdata,
    output logic [7:0]  i2c_device_id,
    output logic [31:0] i2c_dly_cnt_max,
    input  logic [7:0]  i2c_rddata,
    input  logic        i2c_rw_done,
    input  logic        i2c_ack,

    output logic        busy,
    output logic        owner
);

    arb_state_e  state_q, state_d;
    req_t        lat_q, lat_d;
    logic        owner_q, owner_d;
    logic [1:0]  retry_q, retry_d;
    logic [23:0] tmo_q, tmo_d;
    logic [7:0]  gap_q, gap_d;
    logic        err_q, err_d;
    logic [7:0]  rd0_q, rd0_d;
    logic [7:0]  rd1_q, rd1_d;

    logic        take;
    logic        gnt;
    req_t        req0, req1;

    assign req0 = '{m0_rd, m0_addr_mode, m0_addr, m0_wrdata, m0_dev_id, m0_dly};
    assign req1 = '{m1_rd, m1_addr_mode, m1_addr, m1_wrdata, m1_dev_id, m1_dly};
    assign take = (state_q == IDLE) && (m0_req || m1_req);

    i2c_arb_pick #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .req_i  ({m1_req, m0_req}),
        .take_i (take),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        owner_d = owner_q;
        retry_d = retry_q;
        err_d   = err_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        tmo_d   = '0;
        gap_d   = '0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    lat_d   = gnt ? req1 : req0;
                    owner_d = gnt;
                    state_d = ISSUE;
                end
            end
            // Counter is zero on entry, so in WAIT it equals cycles since the issue pulse.
            ISSUE: begin
                tmo_d   = tmo_q + 24'd1;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 24'd1;
                if (i2c_rw_done) begin
                    if (!i2c_ack) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                        if (lat_q.rd) begin
                            if (owner_q) rd1_d = i2c_rddata;
                            else         rd0_d = i2c_rddata;
                        end
                    end else if (retry_q < 2'(MAX_RETRY)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = GAP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else if (tmo_q == TIMEOUT_CYC - 24'd1) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                if ((GAP_CYC == 8'd0) || (gap_q == GAP_CYC - 8'd1)) begin
                    state_d = ISSUE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            DONE: begin
                retry_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            owner_q <= 1'b0;
            retry_q <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            owner_q <= owner_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign i2c_wrreg_req   = (state_q == ISSUE) && !lat_q.rd;
    assign i2c_rdreg_req   = (state_q == ISSUE) &&  lat_q.rd;
    assign i2c_addr        = lat_q.addr;
    assign i2c_addr_mode   = lat_q.addr_mode;
    assign i2c_wrdata      = lat_q.wrdata;
    assign i2c_device_id   = lat_q.dev_id;
    assign i2c_dly_cnt_max = lat_q.dly;

    assign m0_done   = (state_q == DONE) && !owner_q;
    assign m1_done   = (state_q == DONE) &&  owner_q;
    assign m0_err    = m0_done && err_q;
    assign m1_err    = m1_done && err_q;
    assign m0_rddata = rd0_q;
    assign m1_rddata = rd1_q;

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Directed bench: fixed-priority arbiter against a behavioural i2c_control
// responder, plus a round-robin instance with an always-acking responder.
module tb_i2c_access_arbiter;

    localparam logic [23:0] TMO = 24'd1000;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic        m0_req = 0, m0_rd = 0, m0_addr_mode = 0;
    logic [15:0] m0_addr = 0;
    logic [7:0]  m0_wrdata = 0, m0_dev_id = 0;
    logic [31:0] m0_dly = 0;
    logic        m1_req = 0, m1_rd = 0, m1_addr_mode = 0;
    logic [15:0] m1_addr = 0;
    logic [7:0]  m1_wrdata = 0, m1_dev_id = 0;
    logic [31:0] m1_dly = 0;

    logic        m0_done, m0_err, m1_done, m1_err;
    logic [7:0]  m0_rddata, m1_rddata;
    logic        i2c_wrreg_req, i2c_rdreg_req, i2c_addr_mode;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_wrdata, i2c_device_id;
    logic [31:0] i2c_dly_cnt_max;
    logic [7:0]  i2c_rddata = 0;
    logic        i2c_rw_done, i2c_ack;
    logic        busy, owner;

    i2c_access_arbiter #(
        .ARB_MODE(0), .MAX_RETRY(3), .TIMEOUT_CYC(TMO), .GAP_CYC(8'd100)
    ) u_dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .m0_req(m0_req), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_addr_mode(m0_addr_mode),
        .m0_wrdata(m0_wrdata), .m0_dev_id(m0_dev_id), .m0_dly(m0_dly),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rddata(m0_rddata),
        .m1_req(m1_req), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_addr_mode(m1_addr_mode),
        .m1_wrdata(m1_wrdata), .m1_dev_id(m1_dev_id), .m1_dly(m1_dly),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rddata(m1_rddata),
        .i2c_wrreg_req(i2c_wrreg_req), .i2c_rdreg_req(i2c_rdreg_req),
        .i2c_addr(i2c_addr), .i2c_addr_mode(i2c_addr_mode), .i2c_wrdata(i2c_wrdata),
        .i2c_device_id(i2c_device_id), .i2c_dly_cnt_max(i2c_dly_cnt_max),
        .i2c_rddata(i2c_rddata), .i2c_rw_done(i2c_rw_done), .i2c_ack(i2c_ack),
        .busy(busy), .owner(owner)
    );

    // Round-robin instance
    logic        rr_req0 = 0, rr_req1 = 0;
    logic        rr_m0_done, rr_m0_err, rr_m1_done, rr_m1_err;
    logic [7:0]  rr_m0_rddata, rr_m1_rddata;
    logic        rr_wr, rr_rd, rr_addr_mode;
    logic [15:0] rr_addr;
    logic [7:0]  rr_wrdata, rr_dev_id;
    logic [31:0] rr_dly;
    logic        rr_rw_done = 0;
    logic        rr_busy, rr_owner;

    i2c_access_arbiter #(
        .ARB_MODE(1), .MAX_RETRY(3), .TIMEOUT_CYC(TMO), .GAP_CYC(8'd100)
    ) u_rr (
        .Clk(Clk), .Rst_n(Rst_n),
        .m0_req(rr_req0), .m0_rd(1'b0), .m0_addr(16'h0001), .m0_addr_mode(1'b0),
        .m0_wrdata(8'h01), .m0_dev_id(8'h60), .m0_dly(32'd0),
        .m0_done(rr_m0_done), .m0_err(rr_m0_err), .m0_rddata(rr_m0_rddata),
        .m1_req(rr_req1), .m1_rd(1'b0), .m1_addr(16'h0002), .m1_addr_mode(1'b0),
        .m1_wrdata(8'h02), .m1_dev_id(8'h42), .m1_dly(32'd0),
        .m1_done(rr_m1_done), .m1_err(rr_m1_err), .m1_rddata(rr_m1_rddata),
        .i2c_wrreg_req(rr_wr), .i2c_rdreg_req(rr_rd),
        .i2c_addr(rr_addr), .i2c_addr_mode(rr_addr_mode), .i2c_wrdata(rr_wrdata),
        .i2c_device_id(rr_dev_id), .i2c_dly_cnt_max(rr_dly),
        .i2c_rddata(8'h00), .i2c_rw_done(rr_rw_done), .i2c_ack(1'b0),
        .busy(rr_busy), .owner(rr_owner)
    );

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // i2c_control model: answers lat cycles after a pulse; first nack_cfg answers NACK.
    int         lat = 5;
    int         nack_cfg = 0;
    bit         no_resp = 0;
    logic [7:0] resp_data = 0;
    int         pulse_cnt = 0, rd_pulse_cnt = 0, rwdone_cyc = 0;
    int         pulse_log [0:15];
    int         nack_seen = 0, cnt = 0;
    bit         pending = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending     <= 0;
            cnt         <= 0;
            i2c_rw_done <= 0;
            i2c_ack     <= 0;
        end else begin
            i2c_rw_done <= 0;
            i2c_ack     <= 0;
            if (m0_done || m1_done) nack_seen <= 0;
            if (i2c_wrreg_req || i2c_rdreg_req) begin
                pulse_log[pulse_cnt % 16] <= cyc;
                pulse_cnt <= pulse_cnt + 1;
                if (i2c_rdreg_req) rd_pulse_cnt <= rd_pulse_cnt + 1;
                pending <= !no_resp;
                cnt     <= 1;
            end else if (pending) begin
                if (cnt >= lat) begin
                    pending     <= 0;
                    i2c_rw_done <= 1;
                    i2c_rddata  <= resp_data;
                    rwdone_cyc  <= cyc + 1;
                    if (nack_seen < nack_cfg) begin
                        i2c_ack   <= 1;
                        nack_seen <= nack_seen + 1;
                    end else begin
                        nack_seen <= 0;
                    end
                end
                cnt <= cnt + 1;
            end
        end
    end

    int   rr_cnt = 0;
    logic rr_own_log [0:7];
    always @(posedge Clk) begin
        rr_rw_done <= rr_wr || rr_rd;
        if (rr_wr || rr_rd) begin
            rr_own_log[rr_cnt % 8] <= rr_owner;
            rr_cnt <= rr_cnt + 1;
        end
    end

    int n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input bit p, input int budget, output bit got, output int at);
        got = 0;
        at  = 0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (p ? m1_done : m0_done) begin
                got = 1;
                at  = cyc;
            end
        end
    endtask

    initial begin
        bit got;
        int td, p0, rp0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_pulses", {i2c_wrreg_req, i2c_rdreg_req, m0_done, m1_done, m0_err, m1_err}, 0);
        check("rst_latched", {i2c_addr, i2c_wrdata, i2c_device_id}, 0);
        Rst_n = 1;
        tick();

        // Single write on port 1, response after 50 cycles
        m1_rd = 0; m1_addr = 16'h0011; m1_wrdata = 8'h80; m1_dev_id = 8'h60; m1_dly = 32'd7;
        lat = 50; p0 = pulse_cnt; m1_req = 1;
        tick();
        check("wr_pulse", {i2c_wrreg_req, i2c_rdreg_req}, 2'b10);
        check("wr_fields", {i2c_addr, i2c_wrdata, i2c_device_id}, 32'h0011_8060);
        check("wr_dly", i2c_dly_cnt_max, 32'd7);
        check("wr_owner", owner, 1);
        wait_done(1, 200, got, td);
        check("wr_done_seen", got, 1);
        check("wr_err", m1_err, 0);
        check("wr_done_latency", td - rwdone_cyc, 1);
        m1_req = 0;
        tick();
        check("wr_pulse_count", pulse_cnt - p0, 1);
        check("wr_idle_after_done", busy, 0);

        // Simultaneous requests, fixed priority
        m0_rd = 0; m0_addr = 16'h1234; m0_addr_mode = 1; m0_wrdata = 8'hA5; m0_dev_id = 8'h42;
        m1_addr = 16'h0055; m1_wrdata = 8'h11;
        lat = 3; m0_req = 1; m1_req = 1;
        tick();
        check("arb0_first_owner", owner, 0);
        check("arb0_first_addr", {i2c_addr_mode, i2c_addr}, 17'h11234);
        wait_done(0, 100, got, td);
        check("arb0_m0_done", got, 1);
        m0_req = 0;
        wait_done(1, 100, got, td);
        check("arb0_m1_done", got, 1);
        check("arb0_second", {owner, i2c_addr}, {1'b1, 16'h0055});
        m1_req = 0;
        tick();

        // Read on port 0, data must hold across a port-1 write
        m0_rd = 1; m0_addr = 16'h300A; resp_data = 8'h26; lat = 4;
        rp0 = rd_pulse_cnt; m0_req = 1;
        tick();
        check("rd_pulse", {i2c_wrreg_req, i2c_rdreg_req}, 2'b01);
        wait_done(0, 100, got, td);
        check("rd_done_seen", got, 1);
        check("rd_data", m0_rddata, 8'h26);
        check("rd_err", m0_err, 0);
        check("rd_pulse_count", rd_pulse_cnt - rp0, 1);
        m0_req = 0; m0_rd = 0;
        resp_data = 8'h99; m1_rd = 0; m1_req = 1;
        wait_done(1, 100, got, td);
        check("rd_hold_m1_done", got, 1);
        check("rd_hold_value", m0_rddata, 8'h26);
        check("wr_no_capture", m1_rddata, 8'h00);
        m1_req = 0;
        tick();

        // Two NACKs then ack: 3 pulses, spacing = lat + 2 + GAP_CYC
        nack_cfg = 2; lat = 5; p0 = pulse_cnt; m0_addr = 16'h0042; m0_req = 1;
        wait_done(0, 1000, got, td);
        check("nack2_done_seen", got, 1);
        check("nack2_err", m0_err, 0);
        check("nack2_pulses", pulse_cnt - p0, 3);
        check("nack2_gap_a", pulse_log[(p0 + 1) % 16] - pulse_log[p0 % 16], 107);
        check("nack2_gap_b", pulse_log[(p0 + 2) % 16] - pulse_log[(p0 + 1) % 16], 107);
        m0_req = 0;
        tick();

        // Four NACKs: retries exhausted
        nack_cfg = 4; p0 = pulse_cnt; m0_req = 1;
        wait_done(0, 1000, got, td);
        check("nack4_done_seen", got, 1);
        check("nack4_err", m0_err, 1);
        check("nack4_pulses", pulse_cnt - p0, 4);
        m0_req = 0; nack_cfg = 0;
        tick();

        // No response: abort exactly TIMEOUT_CYC after issue
        no_resp = 1; p0 = pulse_cnt; m1_req = 1;
        wait_done(1, 1200, got, td);
        check("tmo_done_seen", got, 1);
        check("tmo_err", m1_err, 1);
        check("tmo_latency", td - pulse_log[p0 % 16], 1000);
        m1_req = 0; no_resp = 0;
        tick();

        // rw_done on the last allowed cycle wins over timeout
        lat = 998; p0 = pulse_cnt; m1_req = 1;
        wait_done(1, 1200, got, td);
        check("tmo_edge_done_seen", got, 1);
        check("tmo_edge_err", m1_err, 0);
        check("tmo_edge_latency", td - pulse_log[p0 % 16], 1000);
        m1_req = 0;
        tick();

        // Round-robin with both requests held
        rr_req0 = 1; rr_req1 = 1;
        for (int i = 0; i < 200 && rr_cnt < 4; i++) tick();
        rr_req0 = 0; rr_req1 = 0;
        check("rr_count", rr_cnt >= 4, 1);
        check("rr_sequence", {rr_own_log[0], rr_own_log[1], rr_own_log[2], rr_own_log[3]}, 4'b0101);
        repeat (10) tick();

        // Inputs change and request drops mid-WAIT
        lat = 20; m0_addr = 16'h0A0B; m0_rd = 0; m0_req = 1;
        tick();
        repeat (5) tick();
        m0_addr = 16'hFFFF; m0_req = 0;
        tick();
        check("wd_addr_held", i2c_addr, 16'h0A0B);
        wait_done(0, 100, got, td);
        check("wd_done_seen", got, 1);
        check("wd_err", m0_err, 0);
        tick();

        // Reset asserted mid-WAIT
        m1_addr = 16'h0C0D; m1_dev_id = 8'h42; m1_req = 1;
        tick();
        repeat (5) tick();
        check("rstmid_busy_before", {busy, owner}, 2'b11);
        m1_req = 0; Rst_n = 0;
        #1;
        check("rstmid_outs", {busy, owner, i2c_wrreg_req, i2c_rdreg_req, m0_done, m1_done, m0_err, m1_err}, 0);
        check("rstmid_latched", {i2c_addr, i2c_device_id, i2c_wrdata}, 0);
        check("rstmid_rddata", {m0_rddata, m1_rddata}, 0);
        tick();
        Rst_n = 1;
        p0 = pulse_cnt; got = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m0_done || m1_done) got = 1;
        end
        check("rstmid_no_pulse", pulse_cnt - p0, 0);
        check("rstmid_no_done", got, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_access_arbiter.md
Name: i2c_access_arbiter

Overview:
Shares the single i2c_control master between two register-access requesters. Port 0 is the camera init sequencer. Port 1 is the runtime tuning path (exposure/gain/AWB writes, ID reads). The block latches a granted request, drives the one-cycle wrreg_req/rdreg_req pulse into i2c_control, and waits for RW_Done. It retries on NACK, enforces a timeout, and returns done/err/rddata to the owner.

Parameters:
ARB_MODE, 0, 0 = fixed priority (port 0 wins), 1 = round-robin.
MAX_RETRY, 3, NACK retries per transaction (0 = no retry); 2-bit retry counter.
TIMEOUT_CYC, 24'd2000000, cycles allowed from issue to RW_Done before abort.
GAP_CYC, 8'd100, idle cycles between a NACK and its retry.

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
m0_req  in  1  level request; held until m0_done
m0_rd  in  1  1 = read, 0 = write
m0_addr  in  16  register address
m0_addr_mode  in  1  0 = 8-bit address, 1 = 16-bit address
m0_wrdata  in  8  write data
m0_dev_id  in  8  8-bit device address (for example 8'h60, 8'h42)
m0_dly  in  32  post-transfer delay passed to dly_cnt_max
m0_done  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_done: 1 = NACK after all retries, or timeout
m0_rddata  out  8  read data, valid from m0_done until the next port-0 grant
m1_req, m1_rd, m1_addr, m1_addr_mode, m1_wrdata, m1_dev_id, m1_dly, m1_done, m1_err, m1_rddata  -  identical to m0_*
i2c_wrreg_req  out  1  write pulse to i2c_control
i2c_rdreg_req  out  1  read pulse to i2c_control
i2c_addr  out  16  latched address
i2c_addr_mode  out  1  latched address mode
i2c_wrdata  out  8  latched write data
i2c_device_id  out  8  latched device id
i2c_dly_cnt_max  out  32  latched delay
i2c_rddata  in  8  read data from i2c_control
i2c_rw_done  in  1  transfer-complete pulse
i2c_ack  in  1  1 = NACK seen, sampled with i2c_rw_done
busy  out  1  high whenever state != IDLE
owner  out  1  port currently or most recently granted

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = port 0; retry counter 0.
- IDLE:
  - Any reqX high: grant one port in the same cycle.
  - Latch that port's rd/addr/addr_mode/wrdata/dev_id/dly into the i2c_* registers.
  - Set owner. Go to ISSUE.
- Arbitration:
  - ARB_MODE 0: port 0 wins when both request.
  - ARB_MODE 1: the port not granted last wins when both request. The pointer updates only on grant.
  - A sole requester always wins.
- ISSUE: assert i2c_rdreg_req (if rd) or i2c_wrreg_req for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - i2c_rw_done & !i2c_ack: go to DONE (ok). If rd, capture i2c_rddata into ownerX_rddata in the same cycle.
  - i2c_rw_done & i2c_ack & retry < MAX_RETRY: increment retry, go to GAP.
  - i2c_rw_done & i2c_ack & retry == MAX_RETRY: go to DONE (err).
  - Timeout counter reaches TIMEOUT_CYC-1 with no rw_done: go to DONE (err). A rw_done arriving in the same cycle takes precedence.
- GAP: count GAP_CYC cycles, then go to ISSUE. Latched fields are unchanged.
- DONE:
  - Pulse ownerX_done for one cycle, with ownerX_err. Clear retry.
  - Return to IDLE. New arbitration happens the following cycle, so there is a minimum 1 idle cycle between grants.
- Request withdrawal: latched fields are immune to changes on the mX_* inputs after grant. If reqX falls mid-transaction, the transfer still completes and done still pulses.
- A requester must drop reqX in the cycle after its done. If reqX is still high in IDLE, it is treated as a new request.
- Latency, best case: grant to i2c pulse = 1 cycle; i2c_rw_done to mX_done = 1 cycle.
- No preemption: a grant is held until DONE.

Decomposition:
- Shared package i2c_arb_pkg holds:
  - state encoding localparams IDLE/ISSUE/WAIT/GAP/DONE;
  - request-bundle width constant REQ_W = 66 ({rd, addr_mode, addr, wrdata, dev_id, dly});
  - defaults for TIMEOUT_CYC and GAP_CYC.
- Sub-module i2c_arb_pick: combinational 2-way fixed/round-robin pick plus registered pointer, parameterised by ARB_MODE.

Test Plan:
- Single write on port 1 (addr 16'h0011, data 8'h80, dev 8'h60); i2c model acks after 50 cycles -> exactly one i2c_wrreg_req pulse; m1_done one cycle after rw_done; m1_err = 0.
- Both ports request in the same cycle, ARB_MODE=0 -> port 0 served first, then port 1. ARB_MODE=1 with both held for 4 transactions -> owner sequence 0,1,0,1.
- Read on port 0; model returns i2c_rddata = 8'h26 -> m0_rddata = 8'h26 at m0_done; value holds while port 1 completes a transaction.
- NACK twice, then ack, MAX_RETRY=3 -> three issue pulses each separated by >= GAP_CYC cycles; m0_err = 0. NACK four times -> four pulses, then m0_err = 1.
- Model never asserts rw_done, TIMEOUT_CYC = 1000 -> mX_done with err = 1 exactly 1000 cycles after issue; next request is granted normally.
- Change m0_addr and drop m0_req mid-WAIT; assert Rst_n low mid-WAIT -> latched i2c_addr unchanged and done still pulses; on reset, all outputs 0, state IDLE, no stray req pulse after release.
